// File: rtl/control_mask_delay_line.sv
// control_mask_delay_line
//   Programmable-depth delay line for per-pixel control/mask words. Each
//   enabled cycle shifts one word in; out_data returns the word that entered
//   depth_q enabled cycles earlier within the current frame. A start-of-frame
//   pulse flushes all stored words and reloads the active depth. Stalls
//   (en=0) freeze the whole line without inserting bubbles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         pixel advance; the line shifts only when en=1
//   sof        start of frame; synchronous flush and depth reload
//   depth      requested delay in enabled cycles, sampled only on sof
//   in_data    mask word entering the line
//   out_data   registered delayed mask word
//   out_valid  registered; 1 once the line holds depth_q words of this frame
//   depth_err  registered; 1 when the last sampled depth was out of range
module control_mask_delay_line #(
  parameter int DATA_W    = 1,
  parameter int MAX_DEPTH = 15,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sof,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [DATA_W-1:0]  in_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               depth_err
);

  // Stage registers only need MAX_DEPTH-1 entries: the final delay slot is
  // out_data itself, and depth 1 bypasses the stages entirely.
  localparam int                 NSTG  = MAX_DEPTH - 1;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);

  logic [DATA_W-1:0]  stage     [NSTG];
  logic [DATA_W-1:0]  stage_nxt [NSTG];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_nxt;
  logic [DEPTH_W-1:0] fill;
  logic [DEPTH_W-1:0] fill_nxt;
  logic [DATA_W-1:0]  out_nxt;
  logic [DATA_W-1:0]  tap;
  logic               valid_nxt;
  logic               err_nxt;

  // A requested depth is usable only inside 1..MAX_DEPTH.
  function automatic logic depth_ok(input logic [DEPTH_W-1:0] d);
    return (d != '0) && (d <= MAX_D);
  endfunction

  // Fill count saturates so a long frame cannot wrap it back below depth_q.
  function automatic logic [DEPTH_W-1:0] sat_inc(input logic [DEPTH_W-1:0] v);
    return (v >= MAX_D) ? MAX_D : v + ONE_D;
  endfunction

  // Tap select: stage[depth_q-2] holds the word that will be depth_q cycles
  // old once it moves into out_data.
  always_comb begin
    tap = '0;
    for (int i = 0; i < NSTG; i++) begin
      if (depth_q == DEPTH_W'(i + 2)) tap = stage[i];
    end
  end

  // Next-state: sof flushes and reloads; en on the same cycle then admits
  // in_data as the first word of the new frame.
  always_comb begin
    depth_nxt = depth_q;
    err_nxt   = depth_err;
    fill_nxt  = fill;
    out_nxt   = out_data;
    stage_nxt = stage;

    if (sof) begin
      depth_nxt = depth_ok(depth) ? depth : MAX_D;
      err_nxt   = !depth_ok(depth);
      fill_nxt  = '0;
      out_nxt   = '0;
      for (int i = 0; i < NSTG; i++) stage_nxt[i] = '0;
      if (en) begin
        stage_nxt[0] = in_data;
        fill_nxt     = ONE_D;
        if (depth_nxt == ONE_D) out_nxt = in_data;
      end
    end else if (en) begin
      stage_nxt[0] = in_data;
      for (int i = 1; i < NSTG; i++) stage_nxt[i] = stage[i-1];
      out_nxt  = (depth_q == ONE_D) ? in_data : tap;
      fill_nxt = sat_inc(fill);
    end

    valid_nxt = (fill_nxt >= depth_nxt);
  end

  // ---- register stage: line contents, output word and frame control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTG; i++) stage[i] <= '0;
      depth_q   <= MAX_D;
      fill      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      depth_err <= 1'b0;
    end else begin
      for (int i = 0; i < NSTG; i++) stage[i] <= stage_nxt[i];
      depth_q   <= depth_nxt;
      fill      <= fill_nxt;
      out_data  <= out_nxt;
      out_valid <= valid_nxt;
      depth_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_control_mask_delay_line.sv
// Testbench for control_mask_delay_line: directed steps with a frame-history
// scoreboard supplying the expected output after every clock edge.
module tb_control_mask_delay_line;

  localparam int DW  = 8;
  localparam int MD  = 15;
  localparam int DPW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           sof = 1'b0;
  logic [DPW-1:0] depth = '0;
  logic [DW-1:0]  in_data = '0;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           depth_err;

  control_mask_delay_line #(
    .DATA_W(DW), .MAX_DEPTH(MD), .DEPTH_W(DPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .depth(depth),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          v;
    logic          e;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] hist [$];
  int            mdepth = MD;
  logic          merr = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mdepth = MD;
    merr   = 1'b0;
  endtask

  // Drive one cycle (called at posedge+1), predict, then compare at next posedge+1.
  task automatic step(input string tag, input logic e, input logic s,
                      input int dep, input logic [DW-1:0] din);
    exp_t x;
    en = e; sof = s; depth = DPW'(dep); in_data = din;
    x.d = out_data_pred();
    if (s) begin
      hist.delete();
      if (dep == 0 || dep > MD) begin mdepth = MD; merr = 1'b1; end
      else begin mdepth = dep; merr = 1'b0; end
      x.d = '0;
    end
    if (e) begin
      hist.push_back(din);
      x.d = (hist.size() >= mdepth) ? hist[hist.size() - mdepth] : '0;
    end
    x.v = (hist.size() >= mdepth);
    x.e = merr;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk({tag, ".data"},  32'(out_data),  32'(x.d));
    chk({tag, ".valid"}, 32'(out_valid), 32'(x.v));
    chk({tag, ".err"},   32'(depth_err), 32'(x.e));
    en = 1'b0; sof = 1'b0;
  endtask

  // Word currently expected on out_data when the line does not advance.
  function automatic logic [DW-1:0] out_data_pred();
    if (hist.size() == 0) return '0;
    return (hist.size() >= mdepth) ? hist[hist.size() - mdepth] : '0;
  endfunction

  initial begin
    logic [DW-1:0] r;
    // Reset state
    #3;
    chk("rst.data", 32'(out_data), 32'h0);
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.err", 32'(depth_err), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Depth 3, continuous enable: outputs 0,0,1,0,1
    step("d3.sof", 0, 1, 3, 0);
    step("d3.w1", 1, 0, 0, 1);
    step("d3.w2", 1, 0, 0, 0);
    step("d3.w3", 1, 0, 0, 1);
    chk("d3.first_valid", 32'(out_valid), 32'h1);
    step("d3.w4", 1, 0, 0, 1);
    step("d3.w5", 1, 0, 0, 0);

    // Depth 3 with stalls: data changes only on enabled cycles
    step("st.sof", 0, 1, 3, 0);
    step("st.e1", 1, 0, 0, 1);
    step("st.s1", 0, 0, 0, 8'hFF);
    step("st.s2", 0, 0, 0, 8'h3C);
    step("st.e2", 1, 0, 0, 0);
    step("st.e3", 1, 0, 0, 1);
    chk("st.third_out", 32'(out_data), 32'h1);

    // Out-of-range depths fall back to MAX_DEPTH with depth_err
    step("er.sof0", 0, 1, 0, 0);
    chk("er.flag0", 32'(depth_err), 32'h1);
    for (int i = 0; i < 16; i++) step("er.lat15", 1, 0, 0, DW'(i + 1));
    step("er.sof16", 0, 1, 16, 0);
    chk("er.depth_q", 32'(dut.depth_q), 32'd15);
    step("er.hold", 1, 0, 4, 8'h11);
    step("er.sof4", 0, 1, 4, 0);
    chk("er.flag_clr", 32'(depth_err), 32'h0);

    // sof+en flushes old words: no stale 1 after switching to depth 1
    step("fl.sof", 0, 1, 2, 0);
    for (int i = 0; i < 5; i++) step("fl.ones", 1, 0, 0, 1);
    step("fl.sof_en", 1, 1, 1, 0);
    chk("fl.out0", 32'(out_data), 32'h0);
    chk("fl.valid1", 32'(out_valid), 32'h1);

    // Depth 1 pass-through; mid-frame depth change is ignored
    step("d1.sof", 0, 1, 1, 0);
    step("d1.a5", 1, 0, 1, 8'hA5);
    chk("d1.out_a5", 32'(out_data), 32'hA5);
    step("d1.dep5", 1, 0, 5, 8'h3C);
    chk("d1.out_3c", 32'(out_data), 32'h3C);

    // Asynchronous reset between edges mid-frame
    step("ar.sof", 0, 1, 3, 0);
    for (int i = 0; i < 4; i++) step("ar.fill", 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.data", 32'(out_data), 32'h0);
    chk("ar.valid", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) step("ar.lat", 1, 0, 0, 1);
    chk("ar.valid14", 32'(out_valid), 32'h0);
    step("ar.lat15", 1, 0, 0, 1);
    chk("ar.valid15", 32'(out_valid), 32'h1);

    // Random mix of stalls, frames and depths (including illegal ones)
    for (int i = 0; i < 60; i++) begin
      r = DW'($urandom);
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 20)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
